// File: rtl/seg7_pkg.sv
// Shared 7-segment constants (active-low, bit6..0 = a..g) and reader FSM state type.
// Common to the BCD-to-7-segment driver and the scan reader so loopback tests agree.
package seg7_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG7_P0 = 7'h01;
  localparam logic [6:0] SEG7_P1 = 7'h4F;
  localparam logic [6:0] SEG7_P2 = 7'h12;
  localparam logic [6:0] SEG7_P3 = 7'h06;
  localparam logic [6:0] SEG7_P4 = 7'h4C;
  localparam logic [6:0] SEG7_P5 = 7'h24;
  localparam logic [6:0] SEG7_P6 = 7'h20;
  localparam logic [6:0] SEG7_P7 = 7'h0F;
  localparam logic [6:0] SEG7_P8 = 7'h00;
  localparam logic [6:0] SEG7_P9 = 7'h04;
  localparam logic [6:0] SEG7_PA = 7'h08;
  localparam logic [6:0] SEG7_PB = 7'h60;
  localparam logic [6:0] SEG7_PC = 7'h31;
  localparam logic [6:0] SEG7_PD = 7'h42;
  localparam logic [6:0] SEG7_PE = 7'h30;
  localparam logic [6:0] SEG7_PF = 7'h38;

  localparam logic [3:0] SEG7_ILLEGAL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2
  } seg7_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational active-low segment pattern to 4-bit code decoder.
// Hex letters A..F are only legal when SEG7_READER_HEX_EN is defined.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg_n,
  output logic [3:0] o_code,
  output logic       o_legal
);

  always_comb begin
    o_code  = SEG7_ILLEGAL;
    o_legal = 1'b0;
    case (i_seg_n)
      SEG7_P0: begin o_code = 4'h0; o_legal = 1'b1; end
      SEG7_P1: begin o_code = 4'h1; o_legal = 1'b1; end
      SEG7_P2: begin o_code = 4'h2; o_legal = 1'b1; end
      SEG7_P3: begin o_code = 4'h3; o_legal = 1'b1; end
      SEG7_P4: begin o_code = 4'h4; o_legal = 1'b1; end
      SEG7_P5: begin o_code = 4'h5; o_legal = 1'b1; end
      SEG7_P6: begin o_code = 4'h6; o_legal = 1'b1; end
      SEG7_P7: begin o_code = 4'h7; o_legal = 1'b1; end
      SEG7_P8: begin o_code = 4'h8; o_legal = 1'b1; end
      SEG7_P9: begin o_code = 4'h9; o_legal = 1'b1; end
`ifdef SEG7_READER_HEX_EN
      SEG7_PA: begin o_code = 4'hA; o_legal = 1'b1; end
      SEG7_PB: begin o_code = 4'hB; o_legal = 1'b1; end
      SEG7_PC: begin o_code = 4'hC; o_legal = 1'b1; end
      SEG7_PD: begin o_code = 4'hD; o_legal = 1'b1; end
      SEG7_PE: begin o_code = 4'hE; o_legal = 1'b1; end
      SEG7_PF: begin o_code = 4'hF; o_legal = 1'b1; end
`endif
      default: begin o_code = SEG7_ILLEGAL; o_legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers per-digit BCD codes from a multiplexed active-low 7-segment bus.
// Optional hex letter decoding is enabled with SEG7_READER_HEX_EN.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg_n,
  input  logic [NDIG-1:0]   an_n,
  output logic [4*NDIG-1:0] bcd_o,
  output logic [NDIG-1:0]   dig_valid_o,
  output logic              frame_o,
  output logic              err_o
);

  localparam logic [8:0] STABLE_TGT = 9'(STABLE_CYC);

  logic [6:0]      r_seg_s1, r_seg_s2, r_ref_seg;
  logic [NDIG-1:0] r_an_s1, r_an_s2, r_ref_an;
  logic [7:0]      r_cnt, w_cnt_next;
  seg7_state_t     r_state, w_state_next;
  logic            r_done, w_done_next;
  logic            w_ref_load, w_cap_fire;
  logic [NDIG-1:0] r_seen, w_cap_mask, w_ref_sel, w_an_sel;
  logic            r_frame, r_err;
  logic            w_an_onehot, w_same;
  logic [3:0]      w_dec_code;
  logic            w_dec_legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_an_s1  <= '1;
      r_an_s2  <= '1;
    end else begin
      r_seg_s1 <= seg_n;
      r_seg_s2 <= r_seg_s1;
      r_an_s1  <= an_n;
      r_an_s2  <= r_an_s1;
    end
  end

  assign w_an_sel    = ~r_an_s2;
  assign w_an_onehot = (w_an_sel != '0) && ((w_an_sel & (w_an_sel - 1'b1)) == '0);
  assign w_same      = (r_an_s2 == r_ref_an) && (r_seg_s2 == r_ref_seg);
  assign w_ref_sel   = ~r_ref_an;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_done_next  = r_done;
    w_ref_load   = 1'b0;
    w_cap_fire   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_an_onehot) begin
          w_state_next = ST_SETTLE;
          w_ref_load   = 1'b1;
          w_cnt_next   = 8'd1;
        end
      end
      ST_SETTLE: begin
        if (!w_same) begin
          if (w_an_onehot) begin
            w_ref_load = 1'b1;
            w_cnt_next = 8'd1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt + 8'd1;
          if ({1'b0, r_cnt} + 9'd1 >= STABLE_TGT) begin
            w_state_next = ST_CAPTURE;
            w_done_next  = 1'b0;
          end
        end
      end
      ST_CAPTURE: begin
        // First cycle captures; afterwards wait for the scan to move on.
        if (!r_done) begin
          w_cap_fire  = 1'b1;
          w_done_next = 1'b1;
        end else if (r_an_s2 != r_ref_an) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_done_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_ref_an  <= '1;
      r_ref_seg <= '1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_done_next;
      if (w_ref_load) begin
        r_ref_an  <= r_an_s2;
        r_ref_seg <= r_seg_s2;
      end
    end
  end

  seg7_pattern_decode u_decode (
    .i_seg_n (r_ref_seg),
    .o_code  (w_dec_code),
    .o_legal (w_dec_legal)
  );

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
    logic [3:0] r_bcd;
    logic       r_valid;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_bcd   <= SEG7_ILLEGAL;
        r_valid <= 1'b0;
      end else if (w_cap_fire && w_ref_sel[gi]) begin
        r_bcd   <= w_dec_legal ? w_dec_code : SEG7_ILLEGAL;
        r_valid <= w_dec_legal;
      end
    end

    assign bcd_o[4*gi +: 4] = r_bcd;
    assign dig_valid_o[gi]  = r_valid;
  end

  assign w_cap_mask = w_cap_fire ? w_ref_sel : '0;

  // A capture landing on the clearing cycle is kept for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seen  <= '0;
      r_frame <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_seen  <= ((&r_seen) ? '0 : r_seen) | w_cap_mask;
      r_frame <= &r_seen;
      if (w_cap_fire && !w_dec_legal) r_err <= 1'b1;
    end
  end

  assign frame_o = r_frame;
  assign err_o   = r_err;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Scoreboard bench for seg7_scan_reader: stimulus queues expected captures,
// a monitor pops and compares each time the reader performs a capture.
module tb_seg7_scan_reader;

  localparam int NDIG = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  an_n = 4'hF;
  logic [15:0] bcd_o;
  logic [3:0]  dig_valid_o;
  logic        frame_o;
  logic        err_o;

  always #5 clk = ~clk;

  seg7_scan_reader #(.NDIG(NDIG), .STABLE_CYC(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .bcd_o       (bcd_o),
    .dig_valid_o (dig_valid_o),
    .frame_o     (frame_o),
    .err_o       (err_o)
  );

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  valid;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   frame_cnt = 0;
  logic frame_prev = 1'b0;

  logic [15:0] m_bcd   = 16'hFFFF;
  logic [3:0]  m_valid = 4'h0;
  logic        m_err   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_n  = an;
    seg_n = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input int k, input logic [6:0] seg, input logic [3:0] code,
                      input logic legal, input int hold);
    logic [3:0] an;
    an = ~(4'(1) << k);
    m_bcd[4*k +: 4] = legal ? code : 4'hF;
    m_valid[k]      = legal;
    if (!legal) m_err = 1'b1;
    sb_q.push_back(exp_t'({m_bcd, m_valid, m_err}));
    drive(an, seg, hold);
  endtask

  // Capture monitor: outputs are compared the cycle after the capture strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && dut.w_cap_fire) begin
        @(negedge clk);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_capture: got bcd=%0h valid=%0h, expected no capture", bcd_o, dig_valid_o);
        end else begin
          e = sb_q.pop_front();
          check("cap_bcd", 32'(bcd_o), 32'(e.bcd));
          check("cap_valid", 32'(dig_valid_o), 32'(e.valid));
          check("cap_err", 32'(err_o), 32'(e.err));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && frame_o) begin
      frame_cnt++;
      if (frame_prev) begin
        n_checks++;
        n_fail++;
        $display("FAIL frame_width: got frame_o high 2 cycles, expected 1");
      end
    end
    frame_prev <= frame_o && !rst;
  end

  task automatic check_outputs(input string tag);
    check({tag, "_bcd"}, 32'(bcd_o), 32'(m_bcd));
    check({tag, "_valid"}, 32'(dig_valid_o), 32'(m_valid));
    check({tag, "_err"}, 32'(err_o), 32'(m_err));
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      an_n  = 4'($urandom);
      seg_n = 7'($urandom);
      @(posedge clk);
      #1;
    end
    check_outputs("reset");
    check("reset_frame", 32'(frame_o), 32'h0);
    an_n  = 4'hF;
    seg_n = 7'h7F;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(4'hF, 7'h7F, 10);
    check_outputs("idle");
    check("idle_frame", 32'(frame_o), 32'h0);

    // Full frame scan of 1,2,3,4.
    scan(0, 7'h4F, 4'h1, 1'b1, 6);
    scan(1, 7'h12, 4'h2, 1'b1, 6);
    scan(2, 7'h06, 4'h3, 1'b1, 6);
    scan(3, 7'h4C, 4'h4, 1'b1, 6);
    drive(4'hF, 7'h7F, 8);
    check("frame_count", 32'(frame_cnt), 32'd1);
    check_outputs("frame");

    // Unstable segments never reach the threshold; then a steady 8.
    drive(4'hE, 7'h01, 1);
    drive(4'hE, 7'h00, 1);
    drive(4'hE, 7'h01, 1);
    scan(0, 7'h00, 4'h8, 1'b1, 8);
    drive(4'hF, 7'h7F, 4);

    // Blank is illegal; error is sticky across a later legal capture.
    scan(2, 7'h7F, 4'hF, 1'b0, 6);
    drive(4'hF, 7'h7F, 4);
    check("err_sticky_set", 32'(err_o), 32'h1);
    scan(2, 7'h12, 4'h2, 1'b1, 6);
    drive(4'hF, 7'h7F, 4);
    check_outputs("rescan");

    // Two digits selected at once is ignored.
    drive(4'hC, 7'h12, 20);
    check_outputs("twolow");
    drive(4'hF, 7'h7F, 4);

    // Reset in the middle of settling aborts the capture.
    drive(4'hD, 7'h24, 4);
    rst   = 1'b1;
    an_n  = 4'hF;
    seg_n = 7'h7F;
    m_bcd = 16'hFFFF;
    m_valid = 4'h0;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst_settle");
    rst = 1'b0;
    drive(4'hF, 7'h7F, 10);
    check_outputs("post_rst");

`ifdef SEG7_READER_HEX_EN
    scan(1, 7'h08, 4'hA, 1'b1, 6);
`else
    scan(1, 7'h08, 4'hF, 1'b0, 6);
`endif
    drive(4'hF, 7'h7F, 8);
    check_outputs("hex_a");

    check("frame_count_end", 32'(frame_cnt), 32'd1);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_capture: got %0d captures outstanding, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
